// File: rtl/toplayici_denetleyici.sv
// Two-requester arbitrated adder: one shared carry-lookahead adder feeding a
// registered result with valid/ready handshake. Define SABIT_ONCELIK_EN for fixed priority.

module carry_lookahead_toplayici #(
    parameter int unsigned BIT = 32
) (
    input  logic [BIT-1:0] deger1_i,
    input  logic [BIT-1:0] deger2_i,
    input  logic           elde_i,
    output logic [BIT-1:0] toplam_o
);

    logic [BIT-1:0] uret;
    logic [BIT-1:0] yay;
    logic [BIT:0]   elde;

    assign uret = deger1_i & deger2_i;
    assign yay  = deger1_i ^ deger2_i;

    // Carries are resolved in 4-bit lookahead groups; each group only waits on its own carry-in.
    always_comb begin
        logic        t;
        int unsigned gs;
        elde    = '0;
        elde[0] = elde_i;
        for (int unsigned i = 0; i < BIT; i++) begin
            gs = i - (i % 4);
            t  = elde[gs];
            for (int unsigned j = gs; j <= i; j++) begin
                t = uret[j] | (yay[j] & t);
            end
            elde[i+1] = t;
        end
    end

    assign toplam_o = yay ^ elde[BIT-1:0];

endmodule

module toplayici_denetleyici #(
    parameter int unsigned BIT = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           istek0_gecerli_i,
    output logic           istek0_hazir_o,
    input  logic [BIT-1:0] istek0_deger1_i,
    input  logic [BIT-1:0] istek0_deger2_i,
    input  logic           istek0_elde_i,
    input  logic           istek1_gecerli_i,
    output logic           istek1_hazir_o,
    input  logic [BIT-1:0] istek1_deger1_i,
    input  logic [BIT-1:0] istek1_deger2_i,
    input  logic           istek1_elde_i,
    output logic           sonuc_gecerli_o,
    input  logic           sonuc_hazir_i,
    output logic [BIT-1:0] sonuc_o,
    output logic           sonuc_elde_o,
    output logic           sonuc_kimlik_o
);

    localparam logic BOSTA = 1'b0;
    localparam logic DOLU  = 1'b1;

    logic           durum;
    logic           kabul;
    logic           kazanan;
    logic           izin;
    logic [BIT-1:0] sec_deger1;
    logic [BIT-1:0] sec_deger2;
    logic           sec_elde;
    logic [BIT-1:0] toplam;
    logic           elde_cikis;

    assign kabul = ~rst_i & ((durum == BOSTA) | sonuc_hazir_i);
    assign izin  = kabul & (istek0_gecerli_i | istek1_gecerli_i);

`ifdef SABIT_ONCELIK_EN
    assign kazanan = ~istek0_gecerli_i;
`else
    logic isaretci;

    // Pointer only breaks ties; a lone requester always wins.
    assign kazanan = (istek0_gecerli_i & istek1_gecerli_i) ? isaretci : istek1_gecerli_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            isaretci <= 1'b0;
        end else if (izin) begin
            isaretci <= ~kazanan;
        end
    end
`endif

    assign istek0_hazir_o = izin & ~kazanan;
    assign istek1_hazir_o = izin & kazanan;

    assign sec_deger1 = kazanan ? istek1_deger1_i : istek0_deger1_i;
    assign sec_deger2 = kazanan ? istek1_deger2_i : istek0_deger2_i;
    assign sec_elde   = kazanan ? istek1_elde_i   : istek0_elde_i;

    carry_lookahead_toplayici #(
        .BIT (BIT)
    ) u_toplayici (
        .deger1_i (sec_deger1),
        .deger2_i (sec_deger2),
        .elde_i   (sec_elde),
        .toplam_o (toplam)
    );

    assign elde_cikis = (sec_deger1[BIT-1] & sec_deger2[BIT-1])
                      | ((sec_deger1[BIT-1] | sec_deger2[BIT-1]) & ~toplam[BIT-1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum          <= BOSTA;
            sonuc_o        <= '0;
            sonuc_elde_o   <= 1'b0;
            sonuc_kimlik_o <= 1'b0;
        end else if (izin) begin
            durum          <= DOLU;
            sonuc_o        <= toplam;
            sonuc_elde_o   <= elde_cikis;
            sonuc_kimlik_o <= kazanan;
        end else if ((durum == DOLU) && sonuc_hazir_i) begin
            durum <= BOSTA;
        end
    end

    assign sonuc_gecerli_o = (durum == DOLU);

endmodule

// File: tb/tb_toplayici_denetleyici.sv
// Randomized bench for toplayici_denetleyici against a transaction-level reference model.
// Define SABIT_ONCELIK_EN here as well when testing the fixed-priority build.

module tb_toplayici_denetleyici;

    localparam int unsigned BIT = 32;

    logic           clk;
    logic           rst;
    logic           v0, v1, h0, h1;
    logic [BIT-1:0] a0, b0, a1, b1;
    logic           c0, c1;
    logic           s_gecerli, s_hazir, s_elde, s_kimlik;
    logic [BIT-1:0] s_deger;

    int unsigned toplam_kontrol = 0;
    int unsigned gecen_kontrol  = 0;

    // Reference model: content of the result register plus who had the last grant.
    logic           m_dolu;
    logic [BIT-1:0] m_sonuc;
    logic           m_elde;
    logic           m_kimlik;
    logic           m_son_kazanan_1;

    toplayici_denetleyici #(
        .BIT (BIT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .istek0_gecerli_i (v0),
        .istek0_hazir_o   (h0),
        .istek0_deger1_i  (a0),
        .istek0_deger2_i  (b0),
        .istek0_elde_i    (c0),
        .istek1_gecerli_i (v1),
        .istek1_hazir_o   (h1),
        .istek1_deger1_i  (a1),
        .istek1_deger2_i  (b1),
        .istek1_elde_i    (c1),
        .sonuc_gecerli_o  (s_gecerli),
        .sonuc_hazir_i    (s_hazir),
        .sonuc_o          (s_deger),
        .sonuc_elde_o     (s_elde),
        .sonuc_kimlik_o   (s_kimlik)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic kontrol(input string etiket, input logic [63:0] gozlenen, input logic [63:0] beklenen);
        toplam_kontrol++;
        if (gozlenen === beklenen) begin
            gecen_kontrol++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", etiket, gozlenen, beklenen);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic adim(input logic r,
                        input logic iv0, input logic [BIT-1:0] ia0, input logic [BIT-1:0] ib0, input logic ic0,
                        input logic iv1, input logic [BIT-1:0] ia1, input logic [BIT-1:0] ib1, input logic ic1,
                        input logic hz);
        logic        grant;
        logic        w;
        logic [BIT:0] t;
        @(negedge clk);
        rst = r; s_hazir = hz;
        v0 = iv0; a0 = ia0; b0 = ib0; c0 = ic0;
        v1 = iv1; a1 = ia1; b1 = ib1; c1 = ic1;
        #1;
        grant = !r && (!m_dolu || hz) && (iv0 || iv1);
`ifdef SABIT_ONCELIK_EN
        w = !iv0;
`else
        if (iv0 && iv1) w = !m_son_kazanan_1;
        else            w = iv1;
`endif
        kontrol("gecerli", 64'(s_gecerli), 64'(m_dolu));
        kontrol("hazir0", 64'(h0), 64'(grant && !w));
        kontrol("hazir1", 64'(h1), 64'(grant && w));
        if (m_dolu) begin
            kontrol("sonuc", 64'(s_deger), 64'(m_sonuc));
            kontrol("elde", 64'(s_elde), 64'(m_elde));
            kontrol("kimlik", 64'(s_kimlik), 64'(m_kimlik));
        end
        if (r) begin
            m_dolu = 1'b0; m_sonuc = '0; m_elde = 1'b0; m_kimlik = 1'b0;
            m_son_kazanan_1 = 1'b1;
        end else if (grant) begin
            if (w) t = {1'b0, ia1} + {1'b0, ib1} + (BIT+1)'(ic1);
            else   t = {1'b0, ia0} + {1'b0, ib0} + (BIT+1)'(ic0);
            m_sonuc = t[BIT-1:0];
            m_elde  = t[BIT];
            m_kimlik = w;
            m_son_kazanan_1 = w;
            m_dolu = 1'b1;
        end else if (m_dolu && hz) begin
            m_dolu = 1'b0;
        end
    endtask

    task automatic bos(input logic r, input logic hz);
        adim(r, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, hz);
    endtask

    task automatic ikisi(input logic hz);
        adim(1'b0, 1'b1, 32'h0000_1111, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, hz);
    endtask

    // Look just after the edge that closes the previous adim.
    task automatic bak(input string etiket, input logic gec, input logic [BIT-1:0] deger,
                       input logic el, input logic kim);
        @(posedge clk);
        #1;
        kontrol({etiket, "_gecerli"}, 64'(s_gecerli), 64'(gec));
        kontrol({etiket, "_sonuc"}, 64'(s_deger), 64'(deger));
        kontrol({etiket, "_elde"}, 64'(s_elde), 64'(el));
        kontrol({etiket, "_kimlik"}, 64'(s_kimlik), 64'(kim));
    endtask

    function automatic logic [BIT-1:0] rastgele_deger();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return BIT'($urandom);
        endcase
    endfunction

    initial begin
        m_dolu = 1'b0; m_sonuc = '0; m_elde = 1'b0; m_kimlik = 1'b0; m_son_kazanan_1 = 1'b1;
        rst = 1'b1; s_hazir = 1'b0;
        v0 = 1'b0; v1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; c0 = 1'b0; c1 = 1'b0;

        bos(1'b1, 1'b0);
        bos(1'b1, 1'b0);
        bak("reset", 1'b0, '0, 1'b0, 1'b0);

        // First cycle out of reset already grants.
        adim(1'b0, 1'b1, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        bak("tekli", 1'b1, 32'h0000_0008, 1'b0, 1'b0);

        adim(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        bak("tasma", 1'b1, 32'h0000_0000, 1'b1, 1'b1);

        bos(1'b0, 1'b1);
        bos(1'b0, 1'b1);

        // Contention from a fresh pointer.
        bos(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ikisi(1'b1);
            @(posedge clk);
            #1;
`ifdef SABIT_ONCELIK_EN
            kontrol("cekisme_kimlik", 64'(s_kimlik), 64'(0));
`else
            kontrol("cekisme_kimlik", 64'(s_kimlik), 64'(i % 2));
`endif
            kontrol("cekisme_gecerli", 64'(s_gecerli), 64'(1));
        end

        // Backpressure, then release with grant and consume together.
        for (int i = 0; i < 3; i++) ikisi(1'b0);
        ikisi(1'b1);
        ikisi(1'b1);

        // Reset with an unconsumed result held.
        ikisi(1'b0);
        bos(1'b1, 1'b0);
        bak("ara_reset", 1'b0, '0, 1'b0, 1'b0);
        ikisi(1'b1);
        bak("reset_sonrasi", 1'b1, 32'h0000_1112, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            adim($urandom_range(0, 49) == 0,
                 $urandom_range(0, 2) != 0, rastgele_deger(), rastgele_deger(), 1'($urandom),
                 $urandom_range(0, 2) != 0, rastgele_deger(), rastgele_deger(), 1'($urandom),
                 $urandom_range(0, 3) != 0);
        end
        bos(1'b0, 1'b1);

        $display("%0d/%0d checks passed", gecen_kontrol, toplam_kontrol);
        $finish;
    end

endmodule

// File: doc/toplayici_denetleyici.md
TOPLAYICI_DENETLEYICI -- requirements
Module: toplayici_denetleyici

Interface
REQ-001 The block SHALL have parameter BIT, default 32, operand and result width.
REQ-002 The block SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port istekN_gecerli_i (N=0,1), input, 1, requester N presents a valid add request.
REQ-005 The block SHALL have port istekN_hazir_o (N=0,1), output, 1, request N accepted this cycle.
REQ-006 The block SHALL have ports istekN_deger1_i and istekN_deger2_i (N=0,1), input, BIT, operands.
REQ-007 The block SHALL have port istekN_elde_i (N=0,1), input, 1, carry-in.
REQ-008 The block SHALL have port sonuc_gecerli_o, output, 1, result register holds a valid result.
REQ-009 The block SHALL have port sonuc_hazir_i, input, 1, consumer accepts the result.
REQ-010 The block SHALL have port sonuc_o, output, BIT, registered sum.
REQ-011 The block SHALL have port sonuc_elde_o, output, 1, registered carry-out of the MSB.
REQ-012 The block SHALL have port sonuc_kimlik_o, output, 1, index of the requester that owns sonuc_o.

Function
REQ-013 The block SHALL instantiate exactly one carry_lookahead_toplayici (BIT-wide) shared by both requesters, with its inputs driven by a combinational mux selected by the grant.
REQ-014 The FSM SHALL have two states: BOSTA (result register empty) and DOLU (result held).
REQ-015 Accept condition: kabul = (state==BOSTA) or (state==DOLU and sonuc_hazir_i); no request is granted when kabul is 0.
REQ-016 When kabul is 1 and at least one request is valid, the block SHALL assert exactly one istekN_hazir_o for the winner, combinationally in the same cycle.
REQ-017 On a grant, the result register SHALL capture the sum, the carry-out, and the winner index on the next edge, giving one-cycle latency; state becomes DOLU.
REQ-018 Carry-out SHALL be computed as (a[BIT-1]&b[BIT-1]) | ((a[BIT-1]|b[BIT-1]) & ~s[BIT-1]), where a and b are the operands and s is the sum.
REQ-019 In DOLU with sonuc_hazir_i=1 and no valid request, the state SHALL become BOSTA and sonuc_gecerli_o SHALL deassert on the next edge.
REQ-020 In DOLU with sonuc_hazir_i=0, sonuc_o, sonuc_elde_o, and sonuc_kimlik_o SHALL stay stable and both hazir outputs SHALL be 0.
REQ-021 Consume and grant in the same cycle SHALL sustain one result per cycle with no bubble.
REQ-022 istekN_hazir_o SHALL never be asserted while istekN_gecerli_i is 0.
REQ-023 Arbitration SHALL be round-robin: a 1-bit pointer names the requester with priority, and after each grant it points to the non-winner; the pointer is unchanged when no grant occurs.
REQ-024 Operand width rules: sum wraps modulo 2^BIT; overflow is reported only via sonuc_elde_o.

Reset
REQ-025 While rst_i=1 at a clock edge, the block SHALL set state BOSTA, sonuc_gecerli_o 0, sonuc_o 0, sonuc_elde_o 0, sonuc_kimlik_o 0, and the pointer to requester 0.
REQ-026 While rst_i=1, both istekN_hazir_o SHALL be 0 and a held result SHALL be discarded.
REQ-027 The first grant after reset release SHALL be possible in the first cycle with rst_i=0.

Configuration
REQ-028 With macro SABIT_ONCELIK_EN defined, arbitration SHALL be fixed priority: requester 0 always wins when valid, and the pointer logic is omitted.
REQ-029 Without SABIT_ONCELIK_EN, arbitration SHALL be round-robin per REQ-023.

Verification
REQ-030 Single request: reset, then istek0 with 0x00000005 + 0x00000003, elde 0, sonuc_hazir_i=1 -> the next cycle shows sonuc_gecerli_o=1, sonuc_o=0x00000008, sonuc_elde_o=0, sonuc_kimlik_o=0.
REQ-031 Overflow: istek1 with 0xFFFFFFFF + 0x00000000, elde 1 -> sonuc_o=0x00000000, sonuc_elde_o=1, sonuc_kimlik_o=1.
REQ-032 Contention: both requesters valid for 4 cycles, sonuc_hazir_i=1 -> grants alternate 0,1,0,1 (all 0 with SABIT_ONCELIK_EN); one result per cycle.
REQ-033 Backpressure: result held, sonuc_hazir_i=0 for 3 cycles with both requests valid -> outputs stable and both hazir outputs 0; on release, grant and consume occur in the same cycle.
REQ-034 Reset mid-operation: DOLU with an unconsumed result, assert rst_i for 1 cycle -> sonuc_gecerli_o=0 and sonuc_o=0 at the next edge; the pointer returns to 0.
